alu_share_ctrl: RTL
===================

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter MULDIV_WAIT, default 3, is the number of extra hold cycles for long ALU ops; legal range 0..15.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 r0_valid  input  1  requester 0 has an operation pending.
REQ-005 r0_ready  output  1  requester 0 operation accepted on this edge when r0_valid is also high.
REQ-006 r0_operation  input  6  ALU function code for requester 0.
REQ-007 r0_ALUOp  input  2  ALU mode for requester 0.
REQ-008 r0_data1, r0_data2  input  32 each  operands for requester 0.
REQ-009 r0_done  output  1  one-cycle pulse; result and result_zero belong to requester 0.
REQ-010 r1_valid, r1_ready, r1_operation, r1_ALUOp, r1_data1, r1_data2, r1_done  same widths and meanings as the r0_* ports, for requester 1.
REQ-011 alu_data1, alu_data2  output  32 each  operands driven to the shared ALU.
REQ-012 alu_operation  output  6  and  alu_ALUOp  output  2  function and mode driven to the ALU.
REQ-013 alu_result  input  32  and  alu_zero  input  1  combinational ALU outputs.
REQ-014 result  output  32  and  result_zero  output  1  registered capture of the last completed op.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-017 In IDLE, at most one rX_ready SHALL be high, combinationally equal to the grant; in EXEC and DONE both readies SHALL be 0.
REQ-018 Grant: only one requester valid -> that requester; both valid -> the one not served last (round-robin via a last_grant register).
REQ-019 On an IDLE edge with a granted valid: latch operation, ALUOp and both operands plus a winner id; set last_grant to the winner; go to EXEC.
REQ-020 The same edge SHALL load the hold counter with MULDIV_WAIT for a long op, else 0.
REQ-021 A long op is ALUOp not in {01, 11} and operation in {001001, 001010, 001011}.
REQ-022 In EXEC, the alu_* outputs SHALL be driven from the latched registers, stable for the whole state.
REQ-023 In IDLE and DONE, the alu_* outputs SHALL be driven to 0.
REQ-024 In EXEC with counter != 0, the counter SHALL decrement by 1 and the FSM SHALL stay in EXEC.
REQ-025 In EXEC with counter == 0: capture alu_result into result and alu_zero into result_zero, set the winner's done register, go to DONE.
REQ-026 In DONE: done SHALL be high for exactly this one cycle; next edge clears done and returns to IDLE.
REQ-027 Latency from the accept edge to the done-high cycle SHALL be 1 cycle for a short op and 1+MULDIV_WAIT cycles for a long op; throughput is one op per 3+hold cycles.
REQ-028 result and result_zero SHALL hold their value until the next capture.
REQ-029 A requester may drop valid or change operands before its accept edge with no effect; after acceptance, input changes SHALL be ignored.
REQ-030 No arithmetic special-casing: divide or modulo by zero SHALL pass through whatever the ALU returns.
REQ-031 Both r0_done and r1_done SHALL never be high in the same cycle.

Reset
REQ-032 reset SHALL force, without waiting for a clock edge: state IDLE; counter, latched regs, result, result_zero, done pulses and busy to 0; last_grant = 1, so r0 wins the first contention.
REQ-033 Reset asserted in EXEC or DONE SHALL abort the op with no done pulse; result SHALL read 0 after reset.
REQ-034 After reset deasserts, the first edge with a valid request SHALL be accepted normally.

Verification
REQ-035 r0 add: operation=000001, ALUOp=00, 5+7 -> r0_done high 1 cycle after the accept edge, result=12, result_zero=0, r1_done stays 0.
REQ-036 Both valid from reset, r0 sub 9-9, r1 or 0xF0|0x0F -> r0 served first (result=0, result_zero=1), then r1 (result=0xFF); with both held valid, grants alternate r0,r1,r0,r1.
REQ-037 r1 divide 100/7, ALUOp=00, MULDIV_WAIT=3 -> alu_* stable for 4 EXEC cycles, done high 4 cycles after accept, result=14.
REQ-038 r0 multiply with ALUOp=01, data2=0x2A -> short path, done 1 cycle after accept, result=0x2A.
REQ-039 Reset pulsed during the 2nd EXEC cycle of a long op -> no done pulse, busy=0, result=0; next r1 request accepted on the first edge after release.
REQ-040 r0 operands changed during EXEC -> result reflects the originally latched operands.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared ALU: round-robin grant, operand latch, optional multi-cycle hold.
// Latency 1 cycle (short op) or 1+MULDIV_WAIT (long op) from accept to done; readies low while busy.
module alu_share_ctrl #(
  parameter int MULDIV_WAIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [5:0]  r0_operation,
  input  logic [1:0]  r0_ALUOp,
  input  logic [31:0] r0_data1,
  input  logic [31:0] r0_data2,
  output logic        r0_done,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [5:0]  r1_operation,
  input  logic [1:0]  r1_ALUOp,
  input  logic [31:0] r1_data1,
  input  logic [31:0] r1_data2,
  output logic        r1_done,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [5:0]  alu_operation,
  output logic [1:0]  alu_ALUOp,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] result,
  output logic        result_zero,
  output logic        busy
);

  localparam logic [3:0] HOLD_CYCLES = 4'(MULDIV_WAIT);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  aluop_q, aluop_d;
  logic [31:0] d1_q, d1_d;
  logic [31:0] d2_q, d2_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        r0_done_q, r0_done_d;
  logic        r1_done_q, r1_done_d;

  logic        grant_vld;
  logic        grant_id;
  logic [5:0]  sel_op;
  logic [1:0]  sel_aluop;
  logic [31:0] sel_d1;
  logic [31:0] sel_d2;
  logic        sel_long;

  // With both valid, the requester not served last wins; otherwise whichever is valid.
  always_comb begin
    grant_vld = r0_valid | r1_valid;
    grant_id  = (r0_valid & r1_valid) ? ~last_grant_q : r1_valid;
    sel_op    = grant_id ? r1_operation : r0_operation;
    sel_aluop = grant_id ? r1_ALUOp     : r0_ALUOp;
    sel_d1    = grant_id ? r1_data1     : r0_data1;
    sel_d2    = grant_id ? r1_data2     : r0_data2;
    sel_long  = (sel_aluop != 2'b01) && (sel_aluop != 2'b11) &&
                ((sel_op == 6'b001001) || (sel_op == 6'b001010) || (sel_op == 6'b001011));
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    aluop_d       = aluop_q;
    d1_d          = d1_q;
    d2_d          = d2_q;
    result_d      = result_q;
    zero_d        = zero_q;
    r0_done_d     = 1'b0;
    r1_done_d     = 1'b0;
    r0_ready      = 1'b0;
    r1_ready      = 1'b0;
    alu_data1     = 32'd0;
    alu_data2     = 32'd0;
    alu_operation = 6'd0;
    alu_ALUOp     = 2'd0;

    case (state_q)
      IDLE: begin
        r0_ready = grant_vld & ~grant_id;
        r1_ready = grant_vld &  grant_id;
        if (grant_vld) begin
          op_d         = sel_op;
          aluop_d      = sel_aluop;
          d1_d         = sel_d1;
          d2_d         = sel_d2;
          id_d         = grant_id;
          last_grant_d = grant_id;
          cnt_d        = sel_long ? HOLD_CYCLES : 4'd0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        alu_data1     = d1_q;
        alu_data2     = d2_q;
        alu_operation = op_q;
        alu_ALUOp     = aluop_q;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d  = alu_result;
          zero_d    = alu_zero;
          r0_done_d = ~id_q;
          r1_done_d = id_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= 4'd0;
      op_q         <= 6'd0;
      aluop_q      <= 2'd0;
      d1_q         <= 32'd0;
      d2_q         <= 32'd0;
      result_q     <= 32'd0;
      zero_q       <= 1'b0;
      r0_done_q    <= 1'b0;
      r1_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      aluop_q      <= aluop_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      r0_done_q    <= r0_done_d;
      r1_done_q    <= r1_done_d;
    end
  end

  assign r0_done     = r0_done_q;
  assign r1_done     = r1_done_q;
  assign result      = result_q;
  assign result_zero = zero_q;
  assign busy        = (state_q != IDLE);

endmodule
